imem_portb_arbiter: RTL and testbench
=====================================

Name: imem_portb_arbiter

Overview:
Arbitrates instruction-memory port B between two requesters: the UART bootloader (write-only) and the LSU read-only IMEM window (read-only). It replaces the fixed write-select mux on port B with a valid/ready arbiter. Writes have priority, reads are protected by a bounded starvation counter, and read data returns through a registered valid/ready response channel. The block sits between the loader/LSU interconnect and the imem port B pins (en_b, we_b, wstrb_b, addr_b, din_b, dout_b).

Parameters:
ADDR_WIDTH, 10, word-address width of imem.
DATA_WIDTH, 32, data width; byte-strobe width is DATA_WIDTH/8.
STARVE_LIMIT, 4, maximum consecutive write grants while a read is pending; range 1..255.

Ports:
clk  input  1  system clock.
nrst  input  1  reset, synchronous, active-low.
wr_valid  input  1  bootloader write request.
wr_ready  output  1  write accepted this cycle when wr_valid && wr_ready.
wr_addr  input  ADDR_WIDTH  write word address.
wr_data  input  DATA_WIDTH  write data; always a full-word write.
rd_valid  input  1  LSU read request.
rd_ready  output  1  read address accepted this cycle when rd_valid && rd_ready.
rd_addr  input  ADDR_WIDTH  read word address.
rd_rvalid  output  1  read data valid.
rd_rready  input  1  LSU consumes read data.
rd_rdata  output  DATA_WIDTH  read data.
mem_en  output  1  to imem en_b.
mem_we  output  1  to imem we_b.
mem_wstrb  output  DATA_WIDTH/8  to imem wstrb_b.
mem_addr  output  ADDR_WIDTH  to imem addr_b.
mem_din  output  DATA_WIDTH  to imem din_b.
mem_dout  input  DATA_WIDTH  from imem dout_b; synchronous read, valid one cycle after the address is sampled.

Behaviour:
- Reset: single clock domain; reset is synchronous and active-low. While nrst=0 the block holds state=IDLE, rd_rvalid=0, rd_rdata=0 and streak=0. In the same condition it forces wr_ready=0, rd_ready=0, mem_en=0, mem_we=0 and mem_wstrb=0.
- States: IDLE (no read outstanding), RD_ISSUED (read sampled by imem last edge), RD_HOLD (rd_rvalid=1, waiting for rd_rready).
- force_read = (state==IDLE) && rd_valid && (streak==STARVE_LIMIT).
- wr_ready = nrst && !force_read.
- rd_ready = nrst && (state==IDLE) && (!wr_valid || force_read).
- wr_grant = wr_valid && wr_ready.
- rd_grant = rd_valid && rd_ready.
- wr_grant and rd_grant are mutually exclusive by construction.
- Memory port is combinational from the grant:
  - wr_grant: mem_en=1, mem_we=1, mem_wstrb=all ones, mem_addr=wr_addr.
  - rd_grant: mem_en=1, mem_we=0, mem_wstrb=0, mem_addr=rd_addr.
  - Otherwise: mem_en=0, mem_we=0, mem_wstrb=0, mem_addr=rd_addr.
  - mem_din=wr_data always.
- Transitions:
  - IDLE -> RD_ISSUED on rd_grant.
  - RD_ISSUED -> RD_HOLD always; rd_rdata<=mem_dout and rd_rvalid<=1 at this edge.
  - RD_HOLD -> IDLE when rd_rready; rd_rvalid<=0 at that edge.
- Read latency: address accepted in cycle N gives rd_rvalid=1 in cycle N+2. Earliest next rd_grant is in the cycle after rd_rready is seen.
- rd_rdata stays stable while rd_rvalid && !rd_rready.
- Writes may be granted in every state. A write in RD_ISSUED does not corrupt the capture, because mem_dout reflects the previous edge's read.
- Starvation counter (8-bit streak):
  - Increments on a wr_grant in IDLE with rd_valid=1.
  - Clears on rd_grant, and in any IDLE cycle with rd_valid=0.
  - Otherwise holds; it never exceeds STARVE_LIMIT.
- Simultaneous requests in IDLE: the write wins unless force_read is set.
- Reset mid-read: an outstanding read is discarded and rd_rvalid is never asserted for it.
- Write back-pressure: wr_ready drops only on a forced-read cycle. The loader must hold wr_valid, wr_addr and wr_data until accepted.

Test Plan:
- Lone write: wr_valid=1, wr_addr=0x005, wr_data=0xDEADBEEF -> same cycle wr_ready=1, mem_en=1, mem_we=1, mem_wstrb=4'hF, mem_addr=0x005; imem word 5 = 0xDEADBEEF.
- Lone read after the write: rd_valid=1, rd_addr=0x005 in cycle N -> rd_ready=1 in N; rd_rvalid=1, rd_rdata=0xDEADBEEF in N+2.
- Backpressure: rd_rready held 0 for 5 cycles after rd_rvalid -> rd_rvalid and rd_rdata stable; rd_ready=0 throughout; rd_ready=1 the cycle after rd_rready=1.
- Starvation with STARVE_LIMIT=4: wr_valid and rd_valid held 1 continuously -> exactly 4 write grants, then one cycle with wr_ready=0 and rd_grant=1; streak returns to 0.
- Write during read: read accepted in N and write to 0x010 in N+1 -> the read returns the pre-write data of its own address, and the write lands in memory.
- Reset mid-read: nrst=0 in the RD_ISSUED cycle -> next cycle state=IDLE, rd_rvalid stays 0, mem_en=0 during reset.

Source files
------------

// File: rtl/imem_portb_arbiter.sv
// -----------------------------------------------------------------------------
// imem_portb_arbiter
//
// Shares instruction-memory port B between the UART bootloader (write-only)
// and the LSU read-only IMEM window (read-only). Writes win by default; a
// bounded starvation counter forces a read grant after STARVE_LIMIT
// consecutive write grants while a read is pending. Read data comes back
// through a registered valid/ready response channel two cycles after the
// address is accepted.
//
// Ports:
//   clk, nrst                      clock, synchronous active-low reset
//   wr_valid/wr_ready              bootloader write handshake
//   wr_addr, wr_data               write word address / full-word data
//   rd_valid/rd_ready              LSU read-address handshake
//   rd_addr                        read word address
//   rd_rvalid/rd_rready, rd_rdata  read response channel
//   mem_en, mem_we, mem_wstrb,
//   mem_addr, mem_din              drive imem en_b/we_b/wstrb_b/addr_b/din_b
//   mem_dout                       imem dout_b (valid one cycle after address)
// -----------------------------------------------------------------------------
module imem_portb_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    nrst,

    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,

    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_rvalid,
    input  logic                    rd_rready,
    output logic [DATA_WIDTH-1:0]   rd_rdata,

    output logic                    mem_en,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_din,
    input  logic [DATA_WIDTH-1:0]   mem_dout
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_ISSUED = 2'd1,
        RD_HOLD   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [7:0]              streak;
    logic [7:0]              streak_next;
    logic                    rvalid_next;
    logic [DATA_WIDTH-1:0]   rdata_next;

    logic                    idle;
    logic                    force_read;
    logic                    wr_grant;
    logic                    rd_grant;

    // ------------------------------------------------------------------
    // Handshake and arbitration
    // ------------------------------------------------------------------
    assign idle       = (state == IDLE);
    assign force_read = idle && rd_valid && (streak == LIMIT);

    // A forced read is the only cycle that back-pressures the loader.
    assign wr_ready = nrst && !force_read;
    assign rd_ready = nrst && idle && (!wr_valid || force_read);

    assign wr_grant = wr_valid && wr_ready;
    assign rd_grant = rd_valid && rd_ready;

    // ------------------------------------------------------------------
    // Memory port drive (combinational from the grant)
    // ------------------------------------------------------------------
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wstrb = '0;
        mem_addr  = rd_addr;
        if (wr_grant) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_wstrb = '1;
            mem_addr  = wr_addr;
        end else if (rd_grant) begin
            mem_en    = 1'b1;
        end
    end

    assign mem_din = wr_data;

    // ------------------------------------------------------------------
    // Read FSM next-state and response registers
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        rvalid_next = rd_rvalid;
        rdata_next  = rd_rdata;
        unique case (state)
            IDLE: begin
                if (rd_grant) begin
                    state_next = RD_ISSUED;
                end
            end
            RD_ISSUED: begin
                // mem_dout holds the word sampled at the previous edge, so a
                // write granted in this cycle cannot disturb the capture.
                state_next  = RD_HOLD;
                rvalid_next = 1'b1;
                rdata_next  = mem_dout;
            end
            RD_HOLD: begin
                if (rd_rready) begin
                    state_next  = IDLE;
                    rvalid_next = 1'b0;
                end
            end
            default: begin
                state_next  = IDLE;
                rvalid_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts write grants that overtook a pending read
    // ------------------------------------------------------------------
    always_comb begin
        streak_next = streak;
        if (idle) begin
            if (rd_grant || !rd_valid) begin
                streak_next = '0;
            end else if (wr_grant && (streak < LIMIT)) begin
                streak_next = streak + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= IDLE;
            streak    <= '0;
            rd_rvalid <= 1'b0;
            rd_rdata  <= '0;
        end else begin
            state     <= state_next;
            streak    <= streak_next;
            rd_rvalid <= rvalid_next;
            rd_rdata  <= rdata_next;
        end
    end

endmodule

// File: tb/tb_imem_portb_arbiter.sv
module tb_imem_portb_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          nrst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_rvalid;
    logic          rd_rready;
    logic [DW-1:0] rd_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imem_portb_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(4)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_addr  (rd_addr),
        .rd_rvalid(rd_rvalid),
        .rd_rready(rd_rready),
        .rd_rdata (rd_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_wstrb(mem_wstrb),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    // Behavioural imem port B: byte-strobed write, read-first synchronous read.
    logic [DW-1:0] tb_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we && mem_wstrb[b]) tb_mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
            end
            mem_dout <= tb_mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: inputs change just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample point for the current cycle: falling edge.
    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) tb_mem[i] = '0;
        mem_dout  = '0;
        nrst      = 1'b0;
        wr_valid  = 1'b1;
        wr_addr   = 10'h3FF;
        wr_data   = 32'hFFFF_FFFF;
        rd_valid  = 1'b1;
        rd_addr   = 10'h001;
        rd_rready = 1'b0;

        // Reset with both requests asserted: everything forced quiet.
        tick(); tick();
        settle();
        chk("rst_wr_ready",  wr_ready,  0);
        chk("rst_rd_ready",  rd_ready,  0);
        chk("rst_mem_en",    mem_en,    0);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_rvalid",    rd_rvalid, 0);
        chk("rst_rdata",     rd_rdata,  0);
        chk("rst_streak",    dut.streak, 0);

        tick();
        nrst = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;
        tick();

        // Lone write to word 5.
        wr_valid = 1'b1; wr_addr = 10'h005; wr_data = 32'hDEAD_BEEF;
        settle();
        chk("lw_wr_ready",  wr_ready,  1);
        chk("lw_mem_en",    mem_en,    1);
        chk("lw_mem_we",    mem_we,    1);
        chk("lw_mem_wstrb", mem_wstrb, 4'hF);
        chk("lw_mem_addr",  mem_addr,  10'h005);
        chk("lw_mem_din",   mem_din,   32'hDEAD_BEEF);
        tick();
        wr_valid = 1'b0;
        settle();
        chk("lw_mem_word5", tb_mem[5], 32'hDEAD_BEEF);
        chk("idle_mem_en",  mem_en,    0);

        // Lone read of word 5 (cycle N), then response back-pressure.
        tick();
        rd_valid = 1'b1; rd_addr = 10'h005;
        settle();
        chk("lr_rd_ready",  rd_ready,  1);
        chk("lr_mem_en",    mem_en,    1);
        chk("lr_mem_we",    mem_we,    0);
        chk("lr_mem_wstrb", mem_wstrb, 0);
        chk("lr_mem_addr",  mem_addr,  10'h005);
        tick();                                  // N+1
        settle();
        chk("lr_n1_rvalid", rd_rvalid, 0);
        chk("lr_n1_ready",  rd_ready,  0);
        tick();                                  // N+2
        settle();
        chk("lr_n2_rvalid", rd_rvalid, 1);
        chk("lr_n2_rdata",  rd_rdata,  32'hDEAD_BEEF);
        chk("lr_n2_ready",  rd_ready,  0);
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            chk("bp_rvalid",   rd_rvalid, 1);
            chk("bp_rdata",    rd_rdata,  32'hDEAD_BEEF);
            chk("bp_rd_ready", rd_ready,  0);
        end
        tick();
        rd_rready = 1'b1;
        settle();
        chk("bp_accept_ready", rd_ready, 0);
        tick();
        rd_rready = 1'b0;
        settle();
        chk("bp_after_rvalid", rd_rvalid, 0);
        chk("bp_after_ready",  rd_ready,  1);   // second read of word 5 granted
        tick();
        rd_valid = 1'b0;
        tick();
        settle();
        chk("rr_rdata", rd_rdata, 32'hDEAD_BEEF);
        rd_rready = 1'b1;
        tick();
        rd_rready = 1'b0;

        // Starvation: both requesters held, four writes then a forced read.
        wr_valid = 1'b1; wr_addr = 10'h020; wr_data = 32'h0BAD_F00D;
        rd_valid = 1'b1; rd_addr = 10'h005;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("st_streak",   dut.streak, k);
            chk("st_wr_ready", wr_ready, 1);
            chk("st_rd_ready", rd_ready, 0);
            chk("st_mem_we",   mem_we,   1);
            tick();
        end
        settle();
        chk("st_force_streak", dut.streak, 4);
        chk("st_force_wr_rdy", wr_ready, 0);
        chk("st_force_rd_rdy", rd_ready, 1);
        chk("st_force_we",     mem_we,   0);
        chk("st_force_addr",   mem_addr, 10'h005);
        tick();
        settle();
        chk("st_cleared",      dut.streak, 0);
        chk("st_wr_in_issued", wr_ready, 1);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        tick();
        settle();
        chk("st_rvalid", rd_rvalid, 1);
        chk("st_rdata",  rd_rdata,  32'hDEAD_BEEF);
        chk("st_mem20",  tb_mem[10'h020], 32'h0BAD_F00D);
        rd_rready = 1'b1;
        tick();
        rd_rready = 1'b0;

        // Write during read: word 0x010 preloaded, read in N, overwritten in N+1.
        wr_valid = 1'b1; wr_addr = 10'h010; wr_data = 32'h1111_2222;
        tick();
        wr_valid = 1'b0;
        rd_valid = 1'b1; rd_addr = 10'h010;
        settle();
        chk("wdr_rd_ready", rd_ready, 1);
        tick();
        rd_valid = 1'b0;
        wr_valid = 1'b1; wr_data = 32'h3333_4444;
        settle();
        chk("wdr_wr_ready", wr_ready, 1);
        chk("wdr_mem_we",   mem_we,   1);
        chk("wdr_mem_addr", mem_addr, 10'h010);
        tick();
        wr_valid = 1'b0;
        settle();
        chk("wdr_rvalid", rd_rvalid, 1);
        chk("wdr_rdata",  rd_rdata,  32'h1111_2222);
        chk("wdr_mem10",  tb_mem[10'h010], 32'h3333_4444);
        rd_rready = 1'b1;
        tick();
        rd_rready = 1'b0;

        // Reset asserted in the RD_ISSUED cycle discards the read.
        rd_valid = 1'b1; rd_addr = 10'h005;
        settle();
        chk("rmr_rd_ready", rd_ready, 1);
        tick();
        rd_valid = 1'b0;
        nrst = 1'b0;
        settle();
        chk("rmr_mem_en",   mem_en,   0);
        chk("rmr_wr_ready", wr_ready, 0);
        tick();
        nrst = 1'b1;
        rd_valid = 1'b1; rd_addr = 10'h010;
        settle();
        chk("rmr_rvalid0",  rd_rvalid, 0);
        chk("rmr_idle_rdy", rd_ready,  1);
        tick();
        rd_valid = 1'b0;
        settle();
        chk("rmr_rvalid1",  rd_rvalid, 0);
        tick();
        settle();
        chk("rmr_new_rvalid", rd_rvalid, 1);
        chk("rmr_new_rdata",  rd_rdata,  32'h3333_4444);
        rd_rready = 1'b1;
        tick();
        rd_rready = 1'b0;
        settle();
        chk("end_rvalid", rd_rvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
